// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package im_loader_pkg;

  // Loader FSM states; CKSUM is only reachable in the checksum build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CKSUM  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef logic [7:0] byte_t;

  // Running mod-256 checksum step.
  function automatic byte_t csum_add(input byte_t sum, input byte_t b);
    return byte_t'(sum + b);
  endfunction

endpackage

// File: rtl/im_loader_word_pack.sv
// Byte-to-word packer: shifts stream bytes in MSB first and flags the 4th byte.
// word is the full big-endian word including the byte being shifted in now,
// so it is valid exactly while word_complete is high.
module im_loader_word_pack
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic        clear,
  input  logic        shift_en,
  input  byte_t       byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [23:0] shift_r;
  logic [1:0]  cnt_r;

  // Shift register and byte-in-word counter; clear realigns at frame start.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      shift_r <= 24'h000000;
      cnt_r   <= 2'd0;
    end else if (clear) begin
      shift_r <= 24'h000000;
      cnt_r   <= 2'd0;
    end else if (shift_en) begin
      shift_r <= {shift_r[15:0], byte_in};
      cnt_r   <= cnt_r + 2'd1;
    end
  end

  assign word          = {shift_r, byte_in};
  assign word_complete = shift_en && (cnt_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: framed byte stream -> 32-bit word writes.
// Holds the core in reset (cpu_rst_f low) until an image has loaded.
// Optional build macro IM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum
// byte and the err output; without it err is tied low.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_f
);

  state_t            state_r;
  state_t            state_s;
  logic              busy_r;
  logic              done_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  word_idx_r;

  logic              xfer_s;
  logic              start_acc_s;
  logic              shift_en_s;
  logic              word_complete_s;
  logic              last_word_s;
  logic [31:0]       word_s;
  logic [LEN_W-1:0]  len_full_s;

  // A byte moves only while the loader is in a receiving state.
  assign xfer_s      = byte_valid && busy_r;
  // start only counts from a resting state; it is ignored mid-frame.
  assign start_acc_s = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
  assign shift_en_s  = xfer_s && (state_r == DATA);
  assign len_full_s  = {len_r[15:8], byte_data};
  assign last_word_s = (word_idx_r == (len_r - LEN_W'(1)));

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CKSUM;
  byte_t sum_r;
  logic  err_r;
  logic  sum_ok_s;
  assign sum_ok_s = (csum_add(sum_r, byte_data) == 8'h00);
`else
  localparam state_t END_ST = DONE;
`endif

  im_loader_word_pack u_word_pack (
    .clk           (clk),
    .rst_f         (rst_f),
    .clear         (start_acc_s),
    .shift_en      (shift_en_s),
    .byte_in       (byte_data),
    .word          (word_s),
    .word_complete (word_complete_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic for the frame parser.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = LEN_HI;
        else       state_s = IDLE;
      end
      LEN_HI: begin
        if (xfer_s) state_s = LEN_LO;
        else        state_s = LEN_HI;
      end
      LEN_LO: begin
        if (xfer_s) begin
          if (len_full_s != {LEN_W{1'b0}}) state_s = DATA;
          else                             state_s = END_ST;
        end else begin
          state_s = LEN_LO;
        end
      end
      DATA: begin
        if (word_complete_s && last_word_s) state_s = END_ST;
        else                                state_s = DATA;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CKSUM: begin
        if (xfer_s) begin
          if (sum_ok_s) state_s = DONE;
          else          state_s = ERR;
        end else begin
          state_s = CKSUM;
        end
      end
`endif
      DONE: begin
        if (start) state_s = LEN_HI;
        else       state_s = DONE;
      end
      ERR: begin
        if (start) state_s = LEN_HI;
        else       state_s = ERR;
      end
      default: state_s = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == LEN_HI) || (state_s == LEN_LO) ||
                (state_s == DATA)   || (state_s == CKSUM);
      done_r <= (state_s == DONE);
    end
  end

  // Write port, word index and captured frame length.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= 32'h00000000;
      word_idx_r <= {LEN_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
    end else begin
      wr_en_r <= word_complete_s;
      if (start_acc_s) begin
        word_idx_r <= {LEN_W{1'b0}};
        len_r      <= {LEN_W{1'b0}};
      end else if (word_complete_s) begin
        wr_addr_r  <= ADDR_W'(word_idx_r);
        wr_data_r  <= word_s;
        word_idx_r <= word_idx_r + LEN_W'(1);
      end else if (xfer_s && (state_r == LEN_HI)) begin
        len_r <= {byte_data, 8'h00};
      end else if (xfer_s && (state_r == LEN_LO)) begin
        len_r <= len_full_s;
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  // Running checksum over every byte of the frame, plus the sticky error flag.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      sum_r <= 8'h00;
      err_r <= 1'b0;
    end else begin
      err_r <= (state_s == ERR);
      if (start_acc_s) begin
        sum_r <= 8'h00;
      end else if (xfer_s) begin
        sum_r <= csum_add(sum_r, byte_data);
      end
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign byte_ready = busy_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cpu_rst_f  = done_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: scoreboard of expected memory writes,
// plus status checks around frame start, completion and async reset.
module tb_im_loader;

  localparam int ADDR_W = 16;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_f = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_rst_f;

  int          total = 0;
  int          bad = 0;
  int          stall_pct = 0;
  logic [47:0] exp_q[$];
  logic [31:0] words[$];

  always #5 clk = ~clk;

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_rst_f  (cpu_rst_f)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_f === 1'b1 && wr_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 64'(wr_en), 64'd0);
      end else begin
        chk("wr", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   guard;
    while (int'($urandom_range(99, 0)) < stall_pct) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard      = 0;
    do begin
      r = byte_ready;
      @(posedge clk); #1;
      guard++;
    end while (!r && guard < 50);
    if (!r) chk("ready_timeout", 64'(r), 64'd1);
    byte_valid = 1'b0;
  endtask

  // Just before the frame's final byte: nothing finished yet, core held in reset.
  task automatic pre_final();
    chk("pre_final", {done, cpu_rst_f, busy}, {1'b0, 1'b0, 1'b1});
  endtask

  // Sends length, words[0..n-1] and (checksum build) the checksum byte.
  task automatic send_body(input int n, input bit good);
    logic [7:0]  ck;
    logic [7:0]  b;
    logic [31:0] w;
    ck = 8'(n >> 8);
    ck = ck + 8'(n);
    send_byte(8'(n >> 8));
    if (n == 0 && !CK) pre_final();
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) begin
        b  = w[8*k +: 8];
        ck = ck + b;
        if (k == 0) exp_q.push_back({16'(i), w});
        if (k == 0 && i == n - 1 && !CK) pre_final();
        send_byte(b);
      end
    end
    if (CK) begin
      pre_final();
      send_byte(good ? (8'd0 - ck) : (8'd1 - ck));
    end
    chk("final", {done, err, cpu_rst_f, busy, byte_ready},
        {good, ~good, good, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("sticky", {done, err, wr_en}, {good, ~good, 1'b0});
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_basic();
    words.delete();
    words.push_back(32'hDEADBEEF);
    words.push_back(32'h12345678);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, then release and start.
    #12;
    chk("rst_outs", {byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_rst_f}, 64'd0);
    rst_f = 1'b1;
    @(posedge clk); #1;
    chk("idle_outs", {byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_rst_f}, 64'd0);
    do_start();
    chk("start_busy", {busy, byte_ready, cpu_rst_f}, {1'b1, 1'b1, 1'b0});

    // Basic two-word frame.
    load_basic();
    send_body(2, 1'b1);

    // Empty frame, then restart with the basic frame.
    words.delete();
    do_start();
    send_body(0, 1'b1);
    do_start();
    chk("restart", {done, cpu_rst_f, busy, err}, {1'b0, 1'b0, 1'b1, 1'b0});
    load_basic();
    send_body(2, 1'b1);

    // Random stalls with random words.
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back($urandom);
    stall_pct = 45;
    do_start();
    send_body(6, 1'b1);
    stall_pct = 0;

    if (CK) begin
      // Bad checksum: writes still happen, err raised, core stays in reset.
      load_basic();
      do_start();
      send_body(2, 1'b0);
    end

    // Async reset while a write strobe is high.
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    chk("wr_before_rst", {wr_en, wr_addr, wr_data}, {1'b1, 16'h0000, 32'hDEADBEEF});
    rst_f = 1'b0;
    #1;
    chk("rst_async_wr", {wr_en, busy, byte_ready, done, cpu_rst_f}, 5'b00000);
    @(negedge clk);
    rst_f = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-word, then a clean frame must realign from byte 0.
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_f = 1'b0;
    #1;
    chk("rst_async_mid", {wr_en, busy, byte_ready, done, cpu_rst_f}, 5'b00000);
    @(negedge clk);
    rst_f = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {busy, done, wr_en}, 3'b000);
    load_basic();
    do_start();
    send_body(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
